// File: rtl/smi_req_arbiter_2x64.sv
// Two-requester SMI request arbiter with in-order response steering, frame-granular grants.
// Pure combinational passthrough once granted; only the FSM, round-robin bit and order FIFO are registered.
module smi_req_arbiter_2x64 #(
    parameter int ORDER_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        reqA_ready,
    input  logic [7:0]  reqA_eofc,
    input  logic [63:0] reqA_data,
    output logic        reqA_stop,

    input  logic        reqB_ready,
    input  logic [7:0]  reqB_eofc,
    input  logic [63:0] reqB_data,
    output logic        reqB_stop,

    output logic        respA_ready,
    output logic [7:0]  respA_eofc,
    output logic [63:0] respA_data,
    input  logic        respA_stop,

    output logic        respB_ready,
    output logic [7:0]  respB_eofc,
    output logic [63:0] respB_data,
    input  logic        respB_stop,

    output logic        memReq_ready,
    output logic [7:0]  memReq_eofc,
    output logic [63:0] memReq_data,
    input  logic        memReq_stop,

    input  logic        memResp_ready,
    input  logic [7:0]  memResp_eofc,
    input  logic [63:0] memResp_data,
    output logic        memResp_stop
);

    localparam int PW = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   rr_b;
    logic   rr_b_nxt;

    logic [ORDER_DEPTH-1:0] order_mem;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   push_id;
    logic                   pop;
    logic                   head_id;
    logic                   head_stop;

    assign fifo_full  = (count == CW'(ORDER_DEPTH));
    assign fifo_empty = (count == '0);
    assign head_id    = order_mem[rd_ptr];
    assign head_stop  = head_id ? respB_stop : respA_stop;

    // Outputs are forced to their idle values while reset is high, not just after the reset edge.
    always_comb begin
        state_nxt    = state;
        rr_b_nxt     = rr_b;
        push         = 1'b0;
        push_id      = 1'b0;
        memReq_ready = 1'b0;
        memReq_eofc  = '0;
        memReq_data  = '0;
        reqA_stop    = 1'b1;
        reqB_stop    = 1'b1;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (!fifo_full && (reqA_ready || reqB_ready)) begin
                        push      = 1'b1;
                        push_id   = reqB_ready && (!reqA_ready || rr_b);
                        state_nxt = push_id ? GRANT_B : GRANT_A;
                    end
                end
                GRANT_A: begin
                    memReq_ready = reqA_ready;
                    memReq_eofc  = reqA_eofc;
                    memReq_data  = reqA_data;
                    reqA_stop    = memReq_stop;
                    if (reqA_ready && !memReq_stop && (reqA_eofc != 8'd0)) begin
                        state_nxt = IDLE;
                        rr_b_nxt  = 1'b1;
                    end
                end
                GRANT_B: begin
                    memReq_ready = reqB_ready;
                    memReq_eofc  = reqB_eofc;
                    memReq_data  = reqB_data;
                    reqB_stop    = memReq_stop;
                    if (reqB_ready && !memReq_stop && (reqB_eofc != 8'd0)) begin
                        state_nxt = IDLE;
                        rr_b_nxt  = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Responses are steered to whichever requester owns the oldest outstanding grant.
    always_comb begin
        respA_ready  = 1'b0;
        respA_eofc   = '0;
        respA_data   = '0;
        respB_ready  = 1'b0;
        respB_eofc   = '0;
        respB_data   = '0;
        memResp_stop = 1'b1;
        pop          = 1'b0;
        if (!reset && !fifo_empty) begin
            memResp_stop = head_stop;
            if (head_id) begin
                respB_ready = memResp_ready;
                respB_eofc  = memResp_eofc;
                respB_data  = memResp_data;
            end else begin
                respA_ready = memResp_ready;
                respA_eofc  = memResp_eofc;
                respA_data  = memResp_data;
            end
            pop = memResp_ready && !head_stop && (memResp_eofc != 8'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rr_b   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            rr_b  <= rr_b_nxt;
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(ORDER_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(ORDER_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry contents need no reset: count and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            order_mem[wr_ptr] <= push_id;
        end
    end

endmodule
